// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Op select values and FSM state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_seq_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// Both algorithms share one 2*WIDTH working register and one adder.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_nx;
    logic [1:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;

    logic               in_signed;
    logic               in_div;
    logic               q_div;
    logic               sa;
    logic               sb;
    logic               b_zero;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     add_s;

    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign sa        = in_signed & a[WIDTH-1];
    assign sb        = in_signed & b[WIDTH-1];
    assign abs_a     = sa ? -a : a;
    assign abs_b     = sb ? -b : b;
    assign b_zero    = (b == '0);

    // Divide needs the bit shifted out of the remainder as carry-in.
    assign add_x = q_div ? acc[2*WIDTH-1:WIDTH-1]
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign add_y = {1'b0, opb};
    assign add_s = q_div ? add_x - add_y : add_x + add_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = (in_div && b_zero) ? FIX : CALC;
                CALC:    if (cnt == '0) state_nx = FIX;
                FIX:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_MULT;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy        <= (state_nx != IDLE);
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        if (start) begin
                            op_q  <= op;
                            cnt   <= CW'(WIDTH - 1);
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            dz_q  <= in_div && b_zero;
                            // Low half holds the multiplier or dividend.
                            acc   <= {{WIDTH{1'b0}}, in_div ? abs_a : abs_b};
                            opb   <= in_div ? abs_b : abs_a;
                        end
                    end
                    CALC: begin
                        cnt <= cnt - CW'(1);
                        if (q_div) begin
                            if (!add_s[WIDTH])
                                acc <= {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                            else
                                acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end else if (acc[0]) begin
                            acc <= {add_s, acc[WIDTH-1:1]};
                        end else begin
                            acc <= {1'b0, acc[2*WIDTH-1:1]};
                        end
                    end
                    FIX: begin
                        done        <= 1'b1;
                        div_by_zero <= dz_q;
                        if (!dz_q) begin
                            if (q_div) begin
                                lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                                hi <= neg_r ? -acc[2*WIDTH-1:WIDTH]
                                            : acc[2*WIDTH-1:WIDTH];
                            end else begin
                                {hi, lo} <= neg_q ? -acc : acc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Randomised self-checking bench for muldiv_seq_unit.
// Expected values come from plain 64-bit arithmetic.
module tb_muldiv_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_chk;
    int          n_pass;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_seq_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
        hi_we = wh;
        lo_we = wl;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit poke);
        longint      lq;
        longint      lr;
        logic [63:0] p;
        logic [31:0] eh;
        logic [31:0] el;
        bit          edz;
        bit          seen;
        int          cyc;
        int          bc;
        int          extra;
        edz = 1'b0;
        eh  = m_hi;
        el  = m_lo;
        case (o)
            2'd0: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                {eh, el} = p;
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                {eh, el} = p;
            end
            2'd2: begin
                if (y == 0) edz = 1'b1;
                else begin
                    lq = longint'($signed(x)) / longint'($signed(y));
                    lr = longint'($signed(x)) % longint'($signed(y));
                    el = lq[31:0];
                    eh = lr[31:0];
                end
            end
            default: begin
                if (y == 0) edz = 1'b1;
                else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("e0_done_low", {63'd0, done}, 64'd0);
        cyc  = 0;
        bc   = int'(busy);
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            if (poke && cyc == 4) begin
                start = 1'b1;
                op    = 2'd3;
                a     = ~x;
                b     = 32'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
            else bc += int'(busy);
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("latency", 64'(cyc), edz ? 64'd1 : 64'd33);
        chk("busy_cycles", 64'(bc), edz ? 64'd1 : 64'd33);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, edz});
        chk("hi", {32'd0, hi}, {32'd0, eh});
        chk("lo", {32'd0, lo}, {32'd0, el});
        m_hi = eh;
        m_lo = el;
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            chk("no_extra_done", 64'(extra), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = 32'($signed($urandom_range(0, 40)) - 20);
            1: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'h7FFF_FFFF;
                    2: v = 32'hFFFF_FFFF;
                    default: v = 32'd1;
                endcase
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int dn;
        n_chk  = 0;
        n_pass = 0;
        m_hi   = '0;
        m_lo   = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'd0;
        a      = '0;
        b      = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        flush  = 1'b0;
        #12;
        chk("reset_outs", {29'd0, busy, done, div_by_zero, hi},
            64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_minneg", {hi, lo}, 64'h0000_0000_8000_0000);

        mt(1'b1, 1'b0, 32'h1111_1111);
        mt(1'b0, 1'b1, 32'h2222_2222);
        do_op(2'd3, 32'd1234, 32'd0, 1'b0);
        chk("dz_hold", {hi, lo}, 64'h1111_1111_2222_2222);

        do_op(2'd1, 32'd1000, 32'd77, 1'b1);

        // Flush mid-MULTU, with a competing start on the flush edge.
        start = 1'b1;
        op    = 2'd1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush_idle", {63'd0, busy}, 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1;
        op    = 2'd2;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
        chk("async_rst_lo", {32'd0, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(2'd1, 32'd6, 32'd7, 1'b0);
        chk("multu_6x7", {hi, lo}, 64'd42);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
            if ($urandom_range(0, 7) == 0)
                mt(1'b1, 1'b1, $urandom);
            do_op(ro, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
